// File: rtl/key_debounce_array_if.sv
// Key bundle between the raw push-buttons and the conditioned outputs of
// key_debounce_array. There is no valid/ready handshake on this interface.
// key_n is a free-running asynchronous level. key_level is a registered level.
// key_press and key_release are registered pulses that are high for exactly
// one Clk cycle.
interface key_debounce_array_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;        // raw buttons, active-low
  logic [NUM_KEYS-1:0] key_level;    // debounced state, active-high
  logic [NUM_KEYS-1:0] key_press;    // one-cycle press (and auto-repeat) pulse
  logic [NUM_KEYS-1:0] key_release;  // one-cycle release pulse

  // Master drives the buttons; slave is the conditioner.
  modport master (output key_n, input key_level, input key_press, input key_release);
  modport slave  (input key_n, output key_level, output key_press, output key_release);
endinterface

// File: rtl/key_debounce_array.sv
// key_debounce_array: NUM_KEYS independent push-button conditioners.
// Each channel has a 2-flop synchroniser, a debounce counter, a clean level
// and one-cycle press/release pulses.
// Optional feature macro: KEY_REPEAT_EN adds auto-repeat press pulses while a
// key is held (REPEAT_DELAY, REPEAT_PERIOD).
module key_debounce_array #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  key_debounce_array_if.slave  keys
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] acc_press, acc_release;
  logic [NUM_KEYS-1:0] rpt_pulse;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  // Synchroniser chain; only s2 is looked at by the debounce logic.
  always_comb begin
    s1_d = keys.key_n;
    s2_d = s1_q;
  end

  // Debounce: count consecutive cycles where s2 disagrees with the accepted
  // level; any agreement restarts the count, a full count flips the level.
  always_comb begin
    level_d     = level_q;
    acc_press   = '0;
    acc_release = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == ~level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]       = '0;
        level_d[i]     = ~s2_q[i];
        acc_press[i]   = ~s2_q[i];
        acc_release[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  // Repeat counter must hold REPEAT_DELAY+REPEAT_PERIOD, so it may be wider
  // than the debounce counter.
  localparam int RPT_NEED = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam int RPT_W    = (RPT_NEED > CNT_W) ? RPT_NEED : CNT_W;
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q [NUM_KEYS];
  logic [RPT_W-1:0] rpt_d [NUM_KEYS];
  logic [RPT_W-1:0] rpt_inc;

  // Auto-repeat: count held cycles from the accepted press; fire at
  // REPEAT_DELAY, then fold back every REPEAT_PERIOD. The release edge wins.
  always_comb begin
    rpt_pulse = '0;
    rpt_inc   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rpt_d[i] = rpt_q[i];
      if (acc_press[i] || acc_release[i] || !level_q[i]) begin
        rpt_d[i] = '0;
      end else begin
        rpt_inc = rpt_q[i] + 1'b1;
        if (rpt_inc == RPT_FIRST) begin
          rpt_pulse[i] = 1'b1;
          rpt_d[i]     = rpt_inc;
        end else if (rpt_inc == RPT_NEXT) begin
          rpt_pulse[i] = 1'b1;
          rpt_d[i]     = RPT_FIRST;
        end else begin
          rpt_d[i] = rpt_inc;
        end
      end
    end
  end

  // Repeat counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) rpt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) rpt_q[i] <= rpt_d[i];
    end
  end
`else
  // No auto-repeat: exactly one press pulse per accepted press.
  always_comb begin
    rpt_pulse = '0;
  end
`endif

  // Registered output pulses.
  always_comb begin
    press_d   = acc_press | rpt_pulse;
    release_d = acc_release;
  end

  // Channel state registers; reset is the released state with no pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q      <= '1;
      s2_q      <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign keys.key_level   = level_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Testbench for key_debounce_array with NUM_KEYS=2, DEBOUNCE_CYCLES=4.
// Expected output events are queued when stimulus is driven. They are
// compared cycle by cycle on the falling edge. Cycles without a queued event
// must show no pulses and an unchanged level.
module tb_key_debounce_array;

  localparam int NK  = 2;
  localparam int LAT = 6;   // edges from drive to output change (4 + 2 sync)
  localparam int EW  = 32 + 3 * NK;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_array_if #(.NUM_KEYS(NK)) kif ();

  key_debounce_array #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
`endif
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .keys(kif.slave)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [NK-1:0] cur_level = '0;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic [NK-1:0] lvl,
                         input logic [NK-1:0] prs, input logic [NK-1:0] rel);
    exp_q.push_back({32'(c), lvl, prs, rel});
  endtask

  // Compare outputs every falling edge while out of reset.
  always @(negedge clk) begin
    logic [EW-1:0] ent;
    if (!rst_n) begin
      cur_level = '0;
    end else if (exp_q.size() > 0 && int'(exp_q[0][EW-1:3*NK]) == cyc) begin
      ent = exp_q.pop_front();
      check("ev_level",   32'(kif.key_level),   32'(ent[3*NK-1:2*NK]));
      check("ev_press",   32'(kif.key_press),   32'(ent[2*NK-1:NK]));
      check("ev_release", 32'(kif.key_release), 32'(ent[NK-1:0]));
      cur_level = ent[3*NK-1:2*NK];
    end else begin
      check("idle_level",   32'(kif.key_level),   32'(cur_level));
      check("idle_press",   32'(kif.key_press),   32'd0);
      check("idle_release", 32'(kif.key_release), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean change of the raw keys; called just after a falling edge.
  task automatic set_keys(input logic [NK-1:0] new_n);
    logic [NK-1:0] chg;
    chg = kif.key_n ^ new_n;
    push_ev(cyc + LAT, ~new_n, chg & ~new_n, chg & new_n);
    kif.key_n = new_n;
  endtask

  // Short low pulse on one key that must be rejected as bounce.
  task automatic bounce(input logic [NK-1:0] mask, input int len);
    kif.key_n = kif.key_n & ~mask;
    wait_cyc(len);
    kif.key_n = kif.key_n | mask;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NK-1:0] m;
    rst_n     = 1'b0;
    kif.key_n = 2'b00;
    #1;
    check("rst_level",   32'(kif.key_level),   32'd0);
    check("rst_press",   32'(kif.key_press),   32'd0);
    check("rst_release", 32'(kif.key_release), 32'd0);
    wait_cyc(3);

    // Keys held through reset: detected as a fresh press on both channels.
    rst_n = 1'b1;
    push_ev(cyc + LAT, 2'b11, 2'b11, 2'b00);
    wait_cyc(10);
    set_keys(2'b11);
    wait_cyc(10);

    // Clean press and release of key 0.
    set_keys(2'b10);
    wait_cyc(10);
    set_keys(2'b11);
    wait_cyc(10);

    // Bounce of 3 cycles is rejected; 4 cycles is exactly enough.
    bounce(2'b01, 3);
    wait_cyc(10);
    set_keys(2'b10);
    wait_cyc(4);
    set_keys(2'b11);
    wait_cyc(10);

    // Key 1 press then release.
    set_keys(2'b01);
    wait_cyc(10);
    set_keys(2'b11);
    wait_cyc(10);

    // Both keys in the same cycle, then an asynchronous reset mid-hold.
    set_keys(2'b00);
    wait_cyc(8);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_level",   32'(kif.key_level),   32'd0);
    check("midrst_press",   32'(kif.key_press),   32'd0);
    check("midrst_release", 32'(kif.key_release), 32'd0);
    kif.key_n = 2'b11;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);

    // Random press/release patterns across both channels.
    for (int k = 0; k < 8; k++) begin
      m = NK'($urandom_range(1, 3));
      set_keys(~m);
      wait_cyc($urandom_range(7, 9));
      set_keys(2'b11);
      wait_cyc($urandom_range(7, 9));
    end
    wait_cyc(4);

`ifdef KEY_REPEAT_EN
    // Held key 0: repeat pulses at 10, 13, 16, 19 after acceptance, none later.
    begin
      int a;
      a = cyc + LAT;
      set_keys(2'b10);
      push_ev(a + 10, 2'b01, 2'b01, 2'b00);
      push_ev(a + 13, 2'b01, 2'b01, 2'b00);
      push_ev(a + 16, 2'b01, 2'b01, 2'b00);
      push_ev(a + 19, 2'b01, 2'b01, 2'b00);
      wait_cyc(20);
      set_keys(2'b11);
      wait_cyc(12);
    end
`endif

    wait_cyc(12);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
